fsm_driver: RTL
===============

FSM_DRIVER -- requirements
Module: fsm_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum cycles spent waiting for the FSM to reach the target in one attempt (legal range 2..255).
REQ-002 SHALL have parameter MAX_RETRY, default 2: number of re-drive attempts allowed after the first attempt times out.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to drive the FSM to target_state; sampled only in IDLE.
REQ-006 SHALL have port target_state, input, 2 bits: requested FSM state; captured together with start.
REQ-007 SHALL have port abort, input, 1 bit: cancels any operation in progress.
REQ-008 SHALL have port fsm_out, input, 3 bits: state reported by the driven FSM.
REQ-009 SHALL have port user_input, output, 3 bits: command code presented to the FSM.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on successful confirmation.
REQ-012 SHALL have port error, output, 1 bit: one-cycle pulse on retry exhaustion.

Function
REQ-013 SHALL implement the states IDLE, DRIVE, CONFIRM, DONE and FAIL, with a registered state register and combinational next-state logic.
REQ-014 SHALL, in IDLE with start=1, capture target_state into tgt, clear the timer and retry count, and enter DRIVE on the next edge.
REQ-015 SHALL ignore start whenever it is sampled outside IDLE.
REQ-016 SHALL drive user_input = {1'b0, tgt} in DRIVE and CONFIRM, and 3'h0 in every other state.
REQ-017 SHALL, in DRIVE, increment the timer every cycle and enter CONFIRM when fsm_out == {1'b0, tgt}.
REQ-018 SHALL, in CONFIRM, enter DONE if fsm_out still matches, and otherwise return to DRIVE without resetting the timer.
REQ-019 SHALL take a timeout when the timer reaches TIMEOUT with no match in that cycle; a match in the same cycle wins.
REQ-020 SHALL, on timeout with retry count < MAX_RETRY, increment the retry count, clear the timer and stay in DRIVE.
REQ-021 SHALL, on timeout with retry count == MAX_RETRY, enter FAIL.
REQ-022 SHALL assert done only in DONE and error only in FAIL, each for exactly 1 cycle, then return to IDLE.
REQ-023 SHALL make the minimum latency from start to done 3 cycles (DRIVE, CONFIRM, DONE) when the FSM already matches.
REQ-024 SHALL, when abort=1 in any non-IDLE state, go to IDLE on the next edge with no done or error pulse; abort takes priority over all other transitions.
REQ-025 SHALL saturate the timer and retry counters, with no wrap-around.

Reset
REQ-026 SHALL, on rst_n low, force state=IDLE, tgt=0, timer=0, retry=0, user_input=3'h0, busy=0, done=0 and error=0 immediately, including mid-operation.
REQ-027 SHALL leave the first edge after reset release in IDLE, acting on start only if it is sampled on that edge.

Structure
REQ-028 SHALL take the state enum and constant CMD_W=3 from shared package fsm_drv_pkg.
REQ-029 SHALL place the timeout counter, with clear, enable and expiry flag, in sub-module fsm_drv_timer.

Verification
REQ-030 SHALL cover: start with target=1 while fsm_out=1 -> user_input=3'h1, done high exactly 3 cycles after start, busy low the following cycle.
REQ-031 SHALL cover: target=2, with fsm_out reaching 2 after 5 cycles -> done with no retry, within TIMEOUT.
REQ-032 SHALL cover: target=3 with fsm_out stuck at 0 -> error pulse after 3×8 drive cycles + 1; done is never asserted.
REQ-033 SHALL cover: fsm_out matches for one cycle and then drops -> return to DRIVE, with done only after a two-cycle match.
REQ-034 SHALL cover: abort in CONFIRM and rst_n low mid-DRIVE -> IDLE, user_input=0, no pulses.
REQ-035 SHALL cover: start asserted while busy -> ignored, so tgt is unchanged.

Source files
------------

// File: rtl/fsm_drv_pkg.sv
// Shared types and constants for the FSM driver and its timeout counter.
package fsm_drv_pkg;

    localparam int CMD_W = 3;
    localparam int TGT_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAIL    = 3'd4
    } drv_state_t;

    // Command code presented to the driven FSM for a given target state.
    function automatic logic [CMD_W-1:0] cmd_for(input logic [TGT_W-1:0] tgt);
        return {1'b0, tgt};
    endfunction

endpackage

// File: rtl/fsm_drv_timer.sv
// Saturating per-attempt cycle counter with synchronous clear and an expiry flag.
// The flag is raised during the last allowed cycle of an attempt, so an attempt
// lasts exactly TIMEOUT enabled cycles.
module fsm_drv_timer
    import fsm_drv_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over counting; counting stops at LIMIT so the value never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q < LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign expired = enable && (count_q >= LAST);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fsm_driver.sv
// Drives an external FSM towards a requested state, confirms it over two
// matching cycles, and retries a bounded number of times before giving up.
module fsm_driver
    import fsm_drv_pkg::*;
#(
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TGT_W-1:0] target_state,
    input  logic             abort,
    input  logic [CMD_W-1:0] fsm_out,
    output logic [CMD_W-1:0] user_input,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

    drv_state_t       state_q, state_d;
    logic [TGT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CMD_W-1:0] user_input_q, user_input_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             timer_clear;
    logic             timer_en;
    logic             timer_expired;
    logic             match;

    assign match = (fsm_out == cmd_for(tgt_q));

    fsm_drv_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Next-state logic; abort overrides everything, and a match beats a timeout
    // that lands on the same cycle. Outputs are derived from the next state so
    // they can be registered alongside it.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        retry_d     = retry_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (start) begin
                    tgt_d   = target_state;
                    retry_d = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                timer_en = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    state_d = ST_CONFIRM;
                end else if (timer_expired) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d     = retry_q + CNT_W'(1);
                        timer_clear = 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_CONFIRM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        user_input_d = ((state_d == ST_DRIVE) || (state_d == ST_CONFIRM))
                       ? cmd_for(tgt_d) : '0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_FAIL);
    end

    // State, captured target, retry count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tgt_q        <= '0;
            retry_q      <= '0;
            user_input_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            retry_q      <= retry_d;
            user_input_q <= user_input_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign user_input = user_input_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
